// File: rtl/aura_mem_arbiter_if.sv
// Bus bundle between the stream loaders/writers, the arbiter and the tagged memory port.
// master drives requests and memory replies; slave is the arbiter itself.
interface aura_mem_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_store;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic [1:0]               proc2mem_command;
    logic [ADDR_W-1:0]        proc2mem_addr;
    logic [DATA_W-1:0]        proc2mem_data;
    logic [TAG_W-1:0]         mem2proc_transaction_tag;
    logic [DATA_W-1:0]        mem2proc_data;
    logic [TAG_W-1:0]         mem2proc_data_tag;
    logic                     idle;
    logic                     err;

    modport master (
        output req_valid, req_store, req_addr, req_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  req_ready, rsp_valid, rsp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, idle, err
    );

    modport slave (
        input  req_valid, req_store, req_addr, req_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output req_ready, rsp_valid, rsp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, idle, err
    );
endinterface

// File: rtl/aura_mem_arbiter.sv
// Round-robin N-channel front end to the tagged memory bus; remembers which channel
// owns each outstanding load tag and steers the returning beat back to it.
module aura_mem_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4,
    parameter int MAX_PER_CH = 8
) (
    input  logic              clock,
    input  logic              reset,
    aura_mem_arbiter_if.slave bus
);
    localparam int CH_W     = $clog2(NUM_CH);
    localparam int CNT_W    = $clog2(MAX_PER_CH + 1);
    localparam int NUM_TAGS = 1 << TAG_W;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [CH_W-1:0]   rr_ptr_reg;
    logic [CH_W-1:0]   rr_ptr_next;
    logic [CNT_W-1:0]  cnt_reg [NUM_CH];
    logic              tbl_valid_reg [NUM_TAGS];
    logic [CH_W-1:0]   tbl_ch_reg [NUM_TAGS];
    logic [NUM_CH-1:0] rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              err_reg;

    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [DATA_W-1:0] data_arr [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] cnt_zero;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] dec;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic              store_sel;
    logic              accept;
    logic              load_accept;
    logic              ret_hit;
    logic [CH_W-1:0]   ret_ch;
    logic              alloc_conflict;
    logic              stray_ret;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
            // Stores never occupy a tag, so only loads are throttled by the counter.
            assign eligible[gi] = bus.req_valid[gi] &
                                  (bus.req_store[gi] | (cnt_reg[gi] < CNT_W'(MAX_PER_CH)));
            assign cnt_zero[gi] = (cnt_reg[gi] == '0);
            assign inc[gi]      = load_accept & (grant_idx == CH_W'(gi));
            assign dec[gi]      = ret_hit & (ret_ch == CH_W'(gi));
        end
    endgenerate

    // Walk from the far end so the channel closest to rr_ptr is the last (winning) write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr_reg) + k) % NUM_CH]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'((int'(rr_ptr_reg) + k) % NUM_CH);
            end
        end
    end

    assign store_sel   = bus.req_store[grant_idx];
    assign accept      = grant_valid & (bus.mem2proc_transaction_tag != '0);
    assign load_accept = accept & ~store_sel;
    assign rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

    assign ret_hit   = (bus.mem2proc_data_tag != '0) & tbl_valid_reg[bus.mem2proc_data_tag];
    assign ret_ch    = tbl_ch_reg[bus.mem2proc_data_tag];
    assign stray_ret = (bus.mem2proc_data_tag != '0) & ~tbl_valid_reg[bus.mem2proc_data_tag];
    // A tag freed in the same cycle it is re-issued is a legal reuse, not a collision.
    assign alloc_conflict = load_accept & tbl_valid_reg[bus.mem2proc_transaction_tag] &
                            ~(ret_hit & (bus.mem2proc_data_tag == bus.mem2proc_transaction_tag));

    always_comb begin
        bus.proc2mem_command = CMD_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.req_ready        = '0;
        if (grant_valid) begin
            bus.proc2mem_command = store_sel ? CMD_STORE : CMD_LOAD;
            bus.proc2mem_addr    = addr_arr[grant_idx];
            bus.proc2mem_data    = data_arr[grant_idx];
        end
        if (accept) begin
            bus.req_ready = NUM_CH'(1) << grant_idx;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.err       = err_reg;
    assign bus.idle      = (&cnt_zero) & ~(|bus.req_valid);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_reg[c] <= '0;
            end
            for (int t = 0; t < NUM_TAGS; t++) begin
                tbl_valid_reg[t] <= 1'b0;
                tbl_ch_reg[t]    <= '0;
            end
        end else begin
            if (accept) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (inc[c] & ~dec[c]) begin
                    cnt_reg[c] <= cnt_reg[c] + CNT_W'(1);
                end else if (dec[c] & ~inc[c]) begin
                    cnt_reg[c] <= cnt_reg[c] - CNT_W'(1);
                end
            end
            // Allocate takes priority over free, so a same-tag reuse ends owned by the new channel.
            for (int t = 0; t < NUM_TAGS; t++) begin
                if (load_accept && (bus.mem2proc_transaction_tag == TAG_W'(t))) begin
                    tbl_valid_reg[t] <= 1'b1;
                    tbl_ch_reg[t]    <= grant_idx;
                end else if (ret_hit && (bus.mem2proc_data_tag == TAG_W'(t))) begin
                    tbl_valid_reg[t] <= 1'b0;
                end
            end
            rsp_valid_reg <= ret_hit ? (NUM_CH'(1) << ret_ch) : '0;
            if (ret_hit) begin
                rsp_data_reg <= bus.mem2proc_data;
            end
            if (alloc_conflict | stray_ret) begin
                err_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aura_mem_arbiter.sv
// Directed bench for aura_mem_arbiter: a per-cycle vector table plus hand-written
// sequences for async reset, stale tags and the outstanding-load limit.
module tb_aura_mem_arbiter;
    localparam int NUM_CH     = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 4;
    localparam int MAX_PER_CH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    aura_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    aura_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_PER_CH(MAX_PER_CH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] addr_tab [NUM_CH] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000, 32'h0000_0300};
    logic [DATA_W-1:0] data_tab [NUM_CH] = '{64'hA000_0000_0000_00A0, 64'hB000_0000_0000_00B1,
                                             64'hC000_0000_0000_00C2, 64'hD000_0000_0000_00D3};

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  store;
        logic [3:0]  tag;
        logic [3:0]  dtag;
        logic [63:0] mdata;
        logic [3:0]  e_ready;
        logic [1:0]  e_cmd;
        int          e_gnt;
        logic [3:0]  e_rsp;
        logic [63:0] e_rdata;
        logic        e_idle;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] store, input logic [3:0] tag,
                                input logic [3:0] dtag, input logic [63:0] mdata,
                                input logic [3:0] e_ready, input logic [1:0] e_cmd, input int e_gnt,
                                input logic [3:0] e_rsp, input logic [63:0] e_rdata,
                                input logic e_idle, input logic e_err);
        vec_t r;
        r.valid = valid;  r.store = store;  r.tag = tag;  r.dtag = dtag;  r.mdata = mdata;
        r.e_ready = e_ready;  r.e_cmd = e_cmd;  r.e_gnt = e_gnt;
        r.e_rsp = e_rsp;  r.e_rdata = e_rdata;  r.e_idle = e_idle;  r.e_err = e_err;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0] store, input logic [3:0] tag,
                         input logic [3:0] dtag, input logic [63:0] mdata);
        bus.req_valid                = valid;
        bus.req_store                = store;
        bus.mem2proc_transaction_tag = tag;
        bus.mem2proc_data_tag        = dtag;
        bus.mem2proc_data            = mdata;
    endtask

    initial begin
        bus.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        bus.req_data = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
        drive(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);

        // single load on ch2, data returns five cycles after accept
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h4, 4'h0, 4'd3, 4'd0, 64'h0, 4'h4, 2'd1,  2, 4'h0, 64'h0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd3, 64'hDEADBEEF_00000001, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0, 4'h0, 2'd0, -1, 4'h4, 64'hDEADBEEF_00000001, 1'b1, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b1, 1'b0));
        // all channels loading; rr_ptr is 3 after the ch2 grant
        vecs.push_back(mk(4'hF, 4'h0, 4'd1, 4'd0, 64'h0, 4'h8, 2'd1, 3, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 4'h0, 4'd2, 4'd0, 64'h0, 4'h1, 2'd1, 0, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 4'h0, 4'd3, 4'd0, 64'h0, 4'h2, 2'd1, 1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 4'h0, 4'd4, 4'd0, 64'h0, 4'h4, 2'd1, 2, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 4'h0, 4'd5, 4'd0, 64'h0, 4'h8, 2'd1, 3, 4'h0, 64'h0, 1'b0, 1'b0));
        // memory rejects ch1 three times while returns drain
        vecs.push_back(mk(4'h2, 4'h0, 4'd0, 4'd1, 64'h11, 4'h0, 2'd1, 1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h2, 4'h0, 4'd0, 4'd2, 64'h22, 4'h0, 2'd1, 1, 4'h8, 64'h11, 1'b0, 1'b0));
        vecs.push_back(mk(4'h2, 4'h0, 4'd0, 4'd0, 64'h0,  4'h0, 2'd1, 1, 4'h1, 64'h22, 1'b0, 1'b0));
        vecs.push_back(mk(4'h2, 4'h0, 4'd6, 4'd0, 64'h0,  4'h2, 2'd1, 1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 4'h0, 4'd7, 4'd0, 64'h0,  4'h4, 2'd1, 2, 4'h0, 64'h0, 1'b0, 1'b0));
        // tag 5 freed for ch3 and reissued to ch1 in the same cycle
        vecs.push_back(mk(4'h2, 4'h0, 4'd5, 4'd5, 64'h55, 4'h2, 2'd1, 1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0,  4'h0, 2'd0, -1, 4'h8, 64'h55, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd5, 64'h5A, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0,  4'h0, 2'd0, -1, 4'h2, 64'h5A, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd3, 64'h33, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd4, 64'h44, 4'h0, 2'd0, -1, 4'h2, 64'h33, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd6, 64'h66, 4'h0, 2'd0, -1, 4'h4, 64'h44, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd7, 64'h77, 4'h0, 2'd0, -1, 4'h2, 64'h66, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0,  4'h0, 2'd0, -1, 4'h4, 64'h77, 1'b1, 1'b0));
        // tag 7 is no longer outstanding
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd7, 64'h99, 4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h0, 4'h0, 4'd0, 4'd0, 64'h0,  4'h0, 2'd0, -1, 4'h0, 64'h0, 1'b1, 1'b1));

        repeat (2) @(negedge clock);
        #1;
        check("rst.command", 64'(bus.proc2mem_command), 64'd0);
        check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst.rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst.idle", 64'(bus.idle), 64'd1);
        check("rst.err", 64'(bus.err), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clock);
            drive(v.valid, v.store, v.tag, v.dtag, v.mdata);
            #1;
            $display("vec %0d: valid=%b tag=%0d dtag=%0d -> ready=%b cmd=%0d rsp=%b idle=%b err=%b",
                     i, v.valid, v.tag, v.dtag, bus.req_ready, bus.proc2mem_command,
                     bus.rsp_valid, bus.idle, bus.err);
            check($sformatf("v%0d.req_ready", i), 64'(bus.req_ready), 64'(v.e_ready));
            check($sformatf("v%0d.command", i), 64'(bus.proc2mem_command), 64'(v.e_cmd));
            check($sformatf("v%0d.addr", i), 64'(bus.proc2mem_addr),
                  (v.e_gnt < 0) ? 64'd0 : 64'(addr_tab[v.e_gnt]));
            check($sformatf("v%0d.data", i), bus.proc2mem_data,
                  (v.e_gnt < 0) ? 64'd0 : data_tab[v.e_gnt]);
            check($sformatf("v%0d.rsp_valid", i), 64'(bus.rsp_valid), 64'(v.e_rsp));
            if (v.e_rsp != 4'h0)
                check($sformatf("v%0d.rsp_data", i), bus.rsp_data, v.e_rdata);
            check($sformatf("v%0d.idle", i), 64'(bus.idle), 64'(v.e_idle));
            check($sformatf("v%0d.err", i), 64'(bus.err), 64'(v.e_err));
        end

        // outstanding ch0 load, then asynchronous reset in the middle of the cycle
        @(negedge clock);
        drive(4'h1, 4'h0, 4'd9, 4'd0, 64'h0);
        #1;
        $display("rst-seq load: ready=%b", bus.req_ready);
        check("rstseq.ready", 64'(bus.req_ready), 64'h1);
        @(negedge clock);
        drive(4'h0, 4'h0, 4'd0, 4'd0, 64'h0);
        #1;
        check("rstseq.idle_busy", 64'(bus.idle), 64'd0);
        check("rstseq.err_before", 64'(bus.err), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        $display("rst-seq async reset: idle=%b err=%b", bus.idle, bus.err);
        check("rstseq.async_idle", 64'(bus.idle), 64'd1);
        check("rstseq.async_err", 64'(bus.err), 64'd0);
        check("rstseq.async_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        drive(4'h0, 4'h0, 4'd0, 4'd9, 64'h9);
        #1;
        check("rstseq.stale_err0", 64'(bus.err), 64'd0);
        @(negedge clock);
        drive(4'h0, 4'h0, 4'd0, 4'd0, 64'h0);
        #1;
        $display("rst-seq stale tag 9: rsp=%b err=%b", bus.rsp_valid, bus.err);
        check("rstseq.stale_err1", 64'(bus.err), 64'd1);
        check("rstseq.stale_rsp", 64'(bus.rsp_valid), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // ch0 saturates at MAX_PER_CH loads while ch1 stores keep flowing
        for (int i = 0; i < 20; i++) begin
            logic exp_load;
            @(negedge clock);
            drive(4'h3, 4'h2, (i < 16) ? TAG_W'((i % 15) + 1) : 4'd2, 4'd0, 64'h0);
            #1;
            exp_load = (i < 16) && (i % 2 == 0);
            $display("limit cyc %0d: ready=%b cmd=%0d", i, bus.req_ready, bus.proc2mem_command);
            check($sformatf("lim%0d.ready", i), 64'(bus.req_ready), exp_load ? 64'h1 : 64'h2);
            check($sformatf("lim%0d.command", i), 64'(bus.proc2mem_command), exp_load ? 64'd1 : 64'd2);
            if (!exp_load)
                check($sformatf("lim%0d.store_data", i), bus.proc2mem_data, data_tab[1]);
        end
        @(negedge clock);
        drive(4'h3, 4'h2, 4'd2, 4'd1, 64'hF0);
        #1;
        $display("limit return tag 1: ready=%b", bus.req_ready);
        check("lim.ret_ready", 64'(bus.req_ready), 64'h2);
        @(negedge clock);
        drive(4'h3, 4'h2, 4'd1, 4'd0, 64'h0);
        #1;
        $display("limit reenabled: ready=%b cmd=%0d rsp=%b", bus.req_ready, bus.proc2mem_command, bus.rsp_valid);
        check("lim.reenable_ready", 64'(bus.req_ready), 64'h1);
        check("lim.reenable_cmd", 64'(bus.proc2mem_command), 64'd1);
        check("lim.ret_rsp", 64'(bus.rsp_valid), 64'h1);
        check("lim.ret_data", bus.rsp_data, 64'hF0);
        @(negedge clock);
        drive(4'h0, 4'h0, 4'd0, 4'd0, 64'h0);
        #1;
        check("lim.err", 64'(bus.err), 64'd0);
        check("lim.idle", 64'(bus.idle), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
